// File: rtl/pio_key_input_irq.sv
// Avalon-MM input PIO for keys and switches: synchronizes and debounces each pin,
// latches selected edges in a sticky edgecapture register and raises a masked level irq.
module pio_key_input_irq #(
  parameter int unsigned      WIDTH           = 2,
  parameter int unsigned      DEBOUNCE_CYCLES = 50000,
  parameter int unsigned      EDGE_TYPE       = 0,
  parameter logic [WIDTH-1:0] IN_RESET_VALUE  = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_RESERVED = 2'd1;
  localparam logic [1:0] ADDR_MASK     = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP  = 2'd3;

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] db_q, db_d;
  logic [WIDTH-1:0] db_dly_q, db_dly_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_sel;
  logic [WIDTH-1:0] clear_bits;
  logic             wr_en;
  logic             unused_wdata;

  // Only the low WIDTH write bits carry meaning; the rest are deliberately dropped.
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= IN_RESET_VALUE;
      sync2_q   <= IN_RESET_VALUE;
      db_q      <= IN_RESET_VALUE;
      db_dly_q  <= IN_RESET_VALUE;
      mask_q    <= '0;
      edgecap_q <= '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_q      <= db_d;
      db_dly_q  <= db_dly_d;
      mask_q    <= mask_d;
      edgecap_q <= edgecap_d;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    sync1_d  = in_port;
    sync2_d  = sync1_q;
    db_dly_d = db_q;
  end

  // A bit is accepted only after it has disagreed with db for DEBOUNCE_CYCLES edges in a row.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    rise = ~db_dly_q & db_q;
    fall = db_dly_q & ~db_q;
    if (EDGE_TYPE == 0) begin
      edge_sel = fall;
    end else if (EDGE_TYPE == 1) begin
      edge_sel = rise;
    end else begin
      edge_sel = rise | fall;
    end
  end

  // Set beats clear so an edge landing on the clearing write is never lost.
  always_comb begin
    wr_en      = chipselect & ~write_n;
    clear_bits = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
    edgecap_d  = (edgecap_q & ~clear_bits) | edge_sel;
    mask_d     = (wr_en && address == ADDR_MASK) ? writedata[WIDTH-1:0] : mask_q;
  end

  assign irq = |(edgecap_q & mask_q);

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:     readdata = 32'(db_q);
      ADDR_RESERVED: readdata = '0;
      ADDR_MASK:     readdata = 32'(mask_q);
      ADDR_EDGECAP:  readdata = 32'(edgecap_q);
      default:       readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_pio_key_input_irq.sv
// Scoreboard bench for pio_key_input_irq: two instances (falling-edge and any-edge capture)
// share one bus and pin set and are checked against a window-based reference model.
module tb_pio_key_input_irq;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic        cs = 1'b0;
  logic        wn = 1'b1;
  logic [31:0] wd = '0;
  logic [1:0]  pins = 2'b11;

  logic [31:0] rd_fall, rd_any;
  logic        irq_fall, irq_any;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    bit          is_read;
    logic [31:0] rd_fall;
    logic [31:0] rd_any;
    logic        irq_fall;
    logic        irq_any;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state: debounced value, its previous value, registers, synced-pin history
  logic [1:0] m_db, m_dbq, m_mask, m_ecap_fall, m_ecap_any;
  logic [1:0] hist[$];

  pio_key_input_irq #(.WIDTH(2), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0), .IN_RESET_VALUE(2'b11)) dut_fall (
    .clk(clk), .reset_n(reset_n), .address(addr), .chipselect(cs), .write_n(wn),
    .writedata(wd), .in_port(pins), .readdata(rd_fall), .irq(irq_fall));

  pio_key_input_irq #(.WIDTH(2), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2), .IN_RESET_VALUE(2'b11)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(addr), .chipselect(cs), .write_n(wn),
    .writedata(wd), .in_port(pins), .readdata(rd_any), .irq(irq_any));

  always #5 clk = ~clk;

  task automatic model_reset();
    m_db = 2'b11;
    m_dbq = 2'b11;
    m_mask = 2'b00;
    m_ecap_fall = 2'b00;
    m_ecap_any = 2'b00;
    hist.delete();
    for (int j = 0; j < D + 2; j++) hist.push_back(2'b11);
  endtask

  // A pin is accepted once the last D synchronized samples all disagree with the debounced value.
  task automatic model_step();
    logic [1:0] new_db, rise, fall, clr;
    bit all_diff;
    new_db = m_db;
    for (int i = 0; i < 2; i++) begin
      all_diff = 1'b1;
      for (int j = 0; j < D; j++) begin
        if (hist[hist.size() - 2 - j][i] == m_db[i]) all_diff = 1'b0;
      end
      if (all_diff) new_db[i] = ~m_db[i];
    end
    rise = ~m_dbq & m_db;
    fall = m_dbq & ~m_db;
    clr = (cs && !wn && addr == 2'd3) ? wd[1:0] : 2'b00;
    m_ecap_fall = (m_ecap_fall & ~clr) | fall;
    m_ecap_any  = (m_ecap_any & ~clr) | rise | fall;
    if (cs && !wn && addr == 2'd2) m_mask = wd[1:0];
    m_dbq = m_db;
    m_db = new_db;
    hist.push_back(pins);
    void'(hist.pop_front());
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a, input logic [1:0] ecap);
    case (a)
      2'd0: return {30'd0, m_db};
      2'd2: return {30'd0, m_mask};
      2'd3: return {30'd0, ecap};
      default: return 32'd0;
    endcase
  endfunction

  task automatic apply_stimulus(input bit rn, input logic [1:0] p, input bit c, input bit w,
                                input logic [1:0] a, input logic [31:0] d);
    exp_t e;
    @(posedge clk);
    if (reset_n) model_step();
    else model_reset();
    #1;
    reset_n = rn;
    if (!reset_n) model_reset();
    pins = p;
    cs = c;
    wn = w;
    addr = a;
    wd = d;
    e.is_read  = c && w;
    e.rd_fall  = model_read(a, m_ecap_fall);
    e.rd_any   = model_read(a, m_ecap_any);
    e.irq_fall = |(m_ecap_fall & m_mask);
    e.irq_any  = |(m_ecap_any & m_mask);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic [1:0] p);
    for (int k = 0; k < n; k++) apply_stimulus(1'b1, p, 1'b1, 1'b1, 2'(k), 32'd0);
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d, input logic [1:0] p);
    apply_stimulus(1'b1, p, 1'b1, 1'b0, a, d);
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: pops one expectation per cycle and compares away from the active edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("irq_fall", {31'd0, irq_fall}, {31'd0, e.irq_fall});
        check_output("irq_any", {31'd0, irq_any}, {31'd0, e.irq_any});
        if (e.is_read) begin
          check_output($sformatf("readdata_fall[a%0d]", addr), rd_fall, e.rd_fall);
          check_output($sformatf("readdata_any[a%0d]", addr), rd_any, e.rd_any);
        end
      end
    end
  end

  initial begin
    logic [1:0] p;
    model_reset();
    #2 reset_n = 1'b0;

    apply_stimulus(1'b0, 2'b11, 1'b1, 1'b1, 2'd0, 32'd0);
    apply_stimulus(1'b0, 2'b11, 1'b1, 1'b1, 2'd3, 32'd0);
    apply_stimulus(1'b1, 2'b11, 1'b1, 1'b1, 2'd2, 32'd0);
    idle(4, 2'b11);

    // Clean press on bit0, then unmask it
    idle(8, 2'b10);
    write_reg(2'd2, 32'h1, 2'b10);
    idle(3, 2'b10);

    // Release, then a bouncing press that never settles long enough
    idle(8, 2'b11);
    idle(3, 2'b10);
    idle(1, 2'b11);
    idle(2, 2'b10);
    idle(8, 2'b11);

    // New falling edge lands on the same cycle as the clearing write
    write_reg(2'd3, 32'h3, 2'b11);
    idle(2, 2'b11);
    idle(1, 2'b10);
    idle(5, 2'b10);
    write_reg(2'd3, 32'h1, 2'b10);
    idle(3, 2'b10);
    write_reg(2'd3, 32'h1, 2'b10);
    idle(3, 2'b10);

    // Press and release bit1, partial clears, ignored writes
    idle(8, 2'b11);
    idle(8, 2'b01);
    idle(8, 2'b11);
    write_reg(2'd3, 32'h1, 2'b11);
    idle(2, 2'b11);
    write_reg(2'd3, 32'h2, 2'b11);
    idle(2, 2'b11);
    write_reg(2'd0, 32'hFFFF_FFFF, 2'b11);
    write_reg(2'd1, 32'hFFFF_FFFF, 2'b11);
    idle(4, 2'b11);

    // Reset in the middle of a debounce with a pending capture
    idle(8, 2'b01);
    idle(3, 2'b00);
    apply_stimulus(1'b0, 2'b00, 1'b1, 1'b1, 2'd3, 32'd0);
    apply_stimulus(1'b0, 2'b00, 1'b1, 1'b1, 2'd0, 32'd0);
    apply_stimulus(1'b1, 2'b00, 1'b1, 1'b1, 2'd0, 32'd0);
    idle(10, 2'b00);
    write_reg(2'd2, 32'h3, 2'b00);
    idle(4, 2'b00);

    // Randomized traffic with pins held for random stretches
    p = 2'b11;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) p = 2'($urandom_range(0, 3));
      apply_stimulus(($urandom_range(0, 399) != 0), p, ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom);
    end

    @(negedge clk);
    @(negedge clk);
    check_output("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
